// File: rtl/bit_serial_alu_ctrl.sv
// rtl/bit_serial_alu_ctrl.sv - bit-serial sequencer driving one external 1-bit ALU slice, LSB first
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   bit_idx_q, bit_idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              zero_q, zero_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;

  logic              op_legal;
  logic              op_arith;

  // xx11 (SLT) and every unlisted code are rejected
  always_comb begin
    op_legal = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  end

  // Among legal codes only ADD and SUB select the adder path of the slice
  assign op_arith = (op_q[1:0] == 2'b10);

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_legal) begin
            a_d       = a;
            b_d       = b;
            op_d      = op;
            bit_idx_d = '0;
            carry_d   = op[2];
            result_d  = '0;
            busy_d    = 1'b1;
            state_d   = S_RUN;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        result_d[bit_idx_q] = alu_result;
        carry_d             = alu_cout;
        bit_idx_d           = bit_idx_q + IDXW'(1);
        if (bit_idx_q == LAST_IDX) begin
          // carry_q here is the carry into the MSB
          carry_out_d = op_arith & alu_cout;
          overflow_d  = op_arith & (alu_cout ^ carry_q);
          zero_d      = (result_d == '0);
          bit_idx_d   = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_idx_q   <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'b0000;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Slice inputs are gated so the slice sees quiet zeros whenever no bit is in flight
  assign alu_a     = (state_q == S_RUN) & a_q[bit_idx_q];
  assign alu_b     = (state_q == S_RUN) & b_q[bit_idx_q];
  assign alu_cin   = (state_q == S_RUN) & carry_q;
  assign alu_op    = op_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb/tb_bit_serial_alu_ctrl.sv - directed table-driven bench for bit_serial_alu_ctrl with a 1-bit slice model
module tb_bit_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             alu_a;
  logic             alu_b;
  logic             alu_cin;
  logic [3:0]       alu_op;
  logic             alu_result;
  logic             alu_cout;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .op         (op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .result     (result),
    .zero       (zero),
    .carry_out  (carry_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classic one-bit slice: op[3] inverts A, op[2] inverts B, op[1:0] selects AND/OR/ADD
  logic sa, sb;
  always_comb begin
    sa = alu_op[3] ? ~alu_a : alu_a;
    sb = alu_op[2] ? ~alu_b : alu_b;
    alu_cout = (sa & sb) | (sa & alu_cin) | (sb & alu_cin);
    case (alu_op[1:0])
      2'b00:   alu_result = sa & sb;
      2'b01:   alu_result = sa | sb;
      2'b10:   alu_result = sa ^ sb ^ alu_cin;
      default: alu_result = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             v;
    logic             err;
  } vec_t;

  vec_t vecs[11];

  task automatic run_op(input logic [3:0] op_i, input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                        input logic [WIDTH-1:0] res_e, input logic z_e, input logic c_e, input logic v_e,
                        input logic err_e, input string tag);
    int busy_cnt;
    int done_cnt;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (err_e) begin
      check({tag, " error pulse"}, error, 1);
      check({tag, " busy on reject"}, busy, 0);
      @(negedge clk);
      check({tag, " error one cycle"}, error, 0);
      check({tag, " no done"}, done, 0);
      check({tag, " result held"}, result, res_e);
      check({tag, " flags held"}, {zero, carry_out, overflow}, {z_e, c_e, v_e});
    end else begin
      busy_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < WIDTH + 3; c++) begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          check({tag, " result"}, result, res_e);
          check({tag, " zero/cout/ovf"}, {zero, carry_out, overflow}, {z_e, c_e, v_e});
          check({tag, " busy low at done"}, busy, 0);
        end
        @(negedge clk);
      end
      check({tag, " busy cycles"}, busy_cnt, WIDTH);
      check({tag, " done pulses"}, done_cnt, 1);
    end
  endtask

  initial begin
    int done_cnt;
    logic [WIDTH-1:0] seen_res;

    vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0001, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1100, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'b1010, 8'h01, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{4'b0111, 8'h01, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          {busy, done, error, result, zero, carry_out, overflow, alu_a, alu_b, alu_cin, alu_op}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v,
             vecs[i].err, $sformatf("vec%0d", i));

    // start reasserted with new operands on RUN cycle 3 must be ignored
    @(negedge clk);
    op = 4'b0010; a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op = 4'b0110; a = 8'hFF; b = 8'h0F; start = 1'b1;
    done_cnt = 0;
    seen_res = '0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      if (done) begin
        done_cnt++;
        seen_res = result;
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("midrun start result", seen_res, 8'h30);
    check("midrun start done count", done_cnt, 1);
    check("midrun start not requeued", busy, 0);

    // asynchronous reset during RUN cycle 4
    @(negedge clk);
    op = 4'b0010; a = 8'h55; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs",
          {busy, done, error, result, zero, carry_out, overflow, alu_a, alu_b, alu_cin, alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < WIDTH + 2; c++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("no activity after reset", done_cnt, 0);
    run_op(4'b0010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "post-reset add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
